// File: rtl/pretrig_capture.sv
// Logic-analyser capture engine: divided sample strobe, pre-trigger ring buffer,
// and AXI-Stream readout of pre-trigger history followed by post-trigger samples.
module pretrig_capture #(
  parameter int DWIDTH    = 32,
  parameter int DIV_W     = 16,
  parameter int PRE_DEPTH = 256,
  parameter int CNT_W     = 24,
  localparam int PW       = $clog2(PRE_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] din,
  input  logic [DIV_W-1:0]  ckdiv,
  input  logic [PW:0]       pre_count,
  input  logic [CNT_W-1:0]  post_count,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig,
  output logic              sample_stb,
  output logic [DWIDTH-1:0] tdata,
  output logic              tvalid,
  input  logic              tready,
  output logic              tlast,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic              overrun
);

  localparam logic [PW:0]      DEPTH_V = (PW+1)'(PRE_DEPTH);
  localparam logic [PW:0]      OCC_ONE = (PW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ARMED, S_POST, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d, ckdiv_q;
  logic              div_chg;
  logic [DWIDTH-1:0] mem [PRE_DEPTH];
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]       occ_q, occ_d, pre_q, pre_d, pre_clamp;
  logic [CNT_W-1:0]  postn_q, postn_d, pcnt_q, pcnt_d;
  logic              ovr_q, ovr_d, done_q, done_d;
  logic              we, re, clr, xfer;

  // A divider setting change restarts the count and swallows that cycle's strobe.
  assign div_chg    = (ckdiv != ckdiv_q);
  assign sample_stb = !div_chg && (div_cnt_q == ckdiv);
  assign div_cnt_d  = (div_chg || sample_stb) ? '0 : div_cnt_q + DIV_W'(1);

  assign pre_clamp = (pre_count > DEPTH_V) ? DEPTH_V : pre_count;

  assign tvalid    = ((state_q == S_POST) || (state_q == S_FLUSH)) && (occ_q != '0);
  assign tlast     = (state_q == S_FLUSH) && (occ_q == OCC_ONE);
  assign tdata     = tvalid ? mem[rd_q] : '0;
  assign xfer      = tvalid && tready;
  assign armed     = (state_q == S_FILL) || (state_q == S_ARMED);
  assign triggered = (state_q == S_POST) || (state_q == S_FLUSH);
  assign done      = done_q;
  assign overrun   = ovr_q;

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    postn_d = postn_q;
    pcnt_d  = pcnt_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          pre_d   = pre_clamp;
          postn_d = (post_count == '0) ? CNT_ONE : post_count;
          ovr_d   = 1'b0;
          state_d = (pre_clamp == '0) ? S_ARMED : S_FILL;
        end
      end
      S_FILL: begin
        if (sample_stb) begin
          we = 1'b1;
          if (occ_q + OCC_ONE == pre_q) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (sample_stb) begin
          if (trig) begin
            we = 1'b1;
            // With a full ring the oldest history word makes room for the trigger sample.
            re      = (occ_q == DEPTH_V);
            pcnt_d  = postn_q - CNT_ONE;
            state_d = (postn_q == CNT_ONE) ? S_FLUSH : S_POST;
          end else if (pre_q != '0) begin
            we = 1'b1;
            re = 1'b1;
          end
        end
      end
      S_POST: begin
        re = xfer;
        if (sample_stb) begin
          if ((occ_q != DEPTH_V) || xfer) we = 1'b1;
          else                            ovr_d = 1'b1;
          pcnt_d = pcnt_q - CNT_ONE;
          if (pcnt_q == CNT_ONE) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        re = xfer;
        if (xfer && tlast) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      ovr_d   = ovr_q;
      done_d  = 1'b0;
      we      = 1'b0;
      re      = 1'b0;
      clr     = 1'b1;
    end
  end

  assign wr_d  = clr ? '0 : wr_q + PW'(we);
  assign rd_d  = clr ? '0 : rd_q + PW'(re);
  assign occ_d = clr ? '0 : occ_q + (PW+1)'(we) - (PW+1)'(re);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      ckdiv_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      occ_q     <= '0;
      pre_q     <= '0;
      postn_q   <= '0;
      pcnt_q    <= '0;
      ovr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      ckdiv_q   <= ckdiv;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      occ_q     <= occ_d;
      pre_q     <= pre_d;
      postn_q   <= postn_d;
      pcnt_q    <= pcnt_d;
      ovr_q     <= ovr_d;
      done_q    <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_q] <= din;
  end

endmodule

// File: tb/tb_pretrig_capture.sv
// Directed bench for pretrig_capture: a table of capture scenarios with expected
// packets, plus hand-written sequences for abort, reset and divider changes.
module tb_pretrig_capture;
  localparam int DW    = 16;
  localparam int DIV_W = 16;
  localparam int DEPTH = 8;
  localparam int CNT_W = 24;
  localparam int PW    = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [DW-1:0]    din;
  logic [DIV_W-1:0] ckdiv;
  logic [PW:0]      pre_count;
  logic [CNT_W-1:0] post_count;
  logic             arm, abort, trig, tready;
  logic             sample_stb, tvalid, tlast, armed, triggered, done, overrun;
  logic [DW-1:0]    tdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pretrig_capture #(.DWIDTH(DW), .DIV_W(DIV_W), .PRE_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .din(din), .ckdiv(ckdiv), .pre_count(pre_count),
    .post_count(post_count), .arm(arm), .abort(abort), .trig(trig),
    .sample_stb(sample_stb), .tdata(tdata), .tvalid(tvalid), .tready(tready),
    .tlast(tlast), .armed(armed), .triggered(triggered), .done(done), .overrun(overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One capture scenario: din carries the strobe index counted from arm (first = 1),
  // trig is held high from strobe trig_at on, tready stays low until rdy_after strobes.
  typedef struct {
    int ckdiv; int pre; int post; int trig_at; int rdy_after;
    int first; int len; int ovr;
  } vec_t;

  vec_t tbl[6];

  task automatic run_case(input vec_t v);
    int   s, nw, last_stb, tlast_cyc, done_cnt, stop_at;
    logic st;
    ckdiv = DIV_W'(v.ckdiv); pre_count = (PW+1)'(v.pre); post_count = CNT_W'(v.post);
    arm = 0; abort = 0; trig = 0; tready = 1;
    repeat (3) @(negedge clk);
    s = 0; nw = 0; last_stb = -1; tlast_cyc = -10; done_cnt = 0; stop_at = 600;
    for (int cyc = 0; cyc < stop_at; cyc++) begin
      arm    = (cyc == 0);
      din    = DW'(s + 1);
      trig   = (cyc > 0) && (s + 1 >= v.trig_at);
      tready = (v.rdy_after == 0) || (s >= v.rdy_after);
      #1;
      if (cyc == 1) begin
        chk("ovr_clear_on_arm", int'(overrun), 0);
        chk("armed_after_arm", int'(armed), 1);
      end
      if (sample_stb) begin
        if (last_stb >= 0) chk("stb_period", cyc - last_stb, v.ckdiv + 1);
        last_stb = cyc;
      end
      if (tvalid && tready) begin
        chk("word", int'(tdata), v.first + nw);
        chk("tlast", int'(tlast), int'(nw == v.len - 1));
        if (tlast) tlast_cyc = cyc;
        nw++;
      end else if (!tvalid) begin
        chk("tdata_idle_zero", int'(tdata), 0);
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", cyc, tlast_cyc + 1);
        if (stop_at == 600) stop_at = cyc + 4;
      end
      st = sample_stb;
      @(negedge clk);
      if (cyc == 0) s = 0;
      else if (st)  s++;
    end
    arm = 0; trig = 0;
    chk("pkt_len", nw, v.len);
    chk("done_count", done_cnt, 1);
    chk("overrun_end", int'(overrun), v.ovr);
    chk("armed_end", int'(armed), 0);
    chk("triggered_end", int'(triggered), 0);
  endtask

  initial begin
    int n, seen;
    int stb_exp[5];
    //          ckdiv pre post trig rdy  first len ovr
    tbl[0] = '{3,    4,  4,   10,  0,   6,    8,  0};
    tbl[1] = '{3,    0,  0,   3,   0,   3,    1,  0};
    tbl[2] = '{0,    7,  3,   9,   0,   2,    10, 0};
    tbl[3] = '{1,    4,  2,   1,   0,   1,    6,  0};
    tbl[4] = '{2,    3,  1,   2,   0,   1,    4,  0};
    tbl[5] = '{3,    4,  10,  10,  19,  6,    8,  1};

    reset = 1; din = '0; ckdiv = DIV_W'(3); pre_count = '0; post_count = '0;
    arm = 0; abort = 0; trig = 0; tready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", int'(tvalid), 0);
    chk("rst_tlast", int'(tlast), 0);
    chk("rst_tdata", int'(tdata), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_triggered", int'(triggered), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_stb", int'(sample_stb), 0);
    reset = 0;

    foreach (tbl[i]) run_case(tbl[i]);

    // arm together with abort is not accepted; sticky overrun survives it
    @(negedge clk);
    arm = 1; abort = 1;
    @(negedge clk);
    arm = 0; abort = 0;
    #1;
    chk("arm_abort_armed", int'(armed), 0);
    chk("arm_abort_ovr_kept", int'(overrun), 1);

    // reset in the middle of a capture
    ckdiv = DIV_W'(1); pre_count = 4'd4; post_count = CNT_W'(4);
    @(negedge clk); arm = 1;
    @(negedge clk); arm = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre_reset_armed", int'(armed), 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    chk("mid_reset_armed", int'(armed), 0);
    chk("mid_reset_tvalid", int'(tvalid), 0);
    chk("mid_reset_overrun", int'(overrun), 0);

    // abort while POST is presenting data
    ckdiv = DIV_W'(1); pre_count = 4'd2; post_count = CNT_W'(8); tready = 0;
    @(negedge clk); arm = 1; din = 16'h00AA;
    @(negedge clk); arm = 0; trig = 1;
    n = 0;
    while (!(triggered && tvalid) && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("post_reached", int'(n < 100), 1);
    abort = 1;
    @(negedge clk);
    abort = 0; tready = 1; trig = 0;
    #1;
    chk("abort_tvalid", int'(tvalid), 0);
    chk("abort_tlast", int'(tlast), 0);
    chk("abort_triggered", int'(triggered), 0);
    chk("abort_armed", int'(armed), 0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (tvalid || tlast || done) seen++;
    end
    chk("abort_quiet", seen, 0);

    // divider setting change while ARMED
    ckdiv = DIV_W'(5); pre_count = '0; post_count = CNT_W'(1); trig = 0;
    @(negedge clk); arm = 1;
    @(negedge clk); arm = 0;
    #1;
    n = 0;
    while (!sample_stb && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("stb_seen_div5", int'(sample_stb), 1);
    @(negedge clk);
    @(negedge clk);
    ckdiv = DIV_W'(1);
    #1;
    chk("ckdiv_chg_no_stb", int'(sample_stb), 0);
    stb_exp[0] = 0; stb_exp[1] = 1; stb_exp[2] = 0; stb_exp[3] = 1; stb_exp[4] = 0;
    foreach (stb_exp[k]) begin
      @(negedge clk); #1;
      chk("stb_after_chg", int'(sample_stb), stb_exp[k]);
    end
    chk("still_armed", int'(armed), 1);
    abort = 1;
    @(negedge clk);
    abort = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pretrig_capture.md
# pretrig_capture

Single-clock logic-analyser capture engine with a pre-trigger ring buffer and a programmable sample-rate divider producing a clock enable. It samples `din` on divided strobes, keeps the most recent `pre_count` samples while waiting for a trigger, then emits the pre-trigger history followed by `post_count` post-trigger samples as an AXI-Stream packet ending in `tlast`. It sits between the input pins and trigger logic on one side and the DMA/stream FIFO on the other, all in the `clk` domain.

## Interface
- `DWIDTH`, 32, sample width in bits
- `DIV_W`, 16, width of divider setting
- `PRE_DEPTH`, 256, ring depth in samples; power of two, at least 2
- `CNT_W`, 24, width of post-trigger count
- `clk`  in  1  system and sampling clock
- `reset`  in  1  synchronous, active-high
- `din`  in  DWIDTH  probe inputs, already synchronised
- `ckdiv`  in  DIV_W  one sample every `ckdiv`+1 clocks
- `pre_count`  in  clog2(PRE_DEPTH)+1  pre-trigger samples; clamped to PRE_DEPTH; latched on arm
- `post_count`  in  CNT_W  post-trigger samples including the trigger sample; 0 treated as 1; latched on arm
- `arm`  in  1  start a capture; honoured only in IDLE
- `abort`  in  1  cancel the capture from any state
- `trig`  in  1  qualified trigger condition for the current `din`
- `sample_stb`  out  1  one-cycle sample strobe, also used by the trigger logic
- `tdata`  out  DWIDTH  stream data; 0 while `tvalid` is low
- `tvalid`  out  1  stream valid
- `tready`  in  1  stream ready
- `tlast`  out  1  final word of the capture
- `armed`  out  1  high in FILL and ARMED
- `triggered`  out  1  high in POST and FLUSH
- `done`  out  1  one-cycle pulse after the `tlast` transfer
- `overrun`  out  1  sticky; a post-trigger sample was dropped; cleared on an accepted arm

## Operation
- Divider: counter runs 0..`ckdiv`. `sample_stb`=1 on the cycle where counter==`ckdiv`, then the counter wraps to 0. With `ckdiv`=0, the strobe is high every cycle. Any change of `ckdiv` from its previous-cycle value resets the counter to 0 and suppresses the strobe that cycle.
- Ring: PRE_DEPTH x DWIDTH memory with read/write pointers that wrap modulo PRE_DEPTH, and an occupancy counter `occ` (0..PRE_DEPTH). Read is asynchronous, so `tdata`=mem[rd] when `tvalid`=1.
- States:
  - IDLE: ring empty. `arm` && !`abort` latches the counts, clears `overrun`, and goes to FILL, or to ARMED if the latched pre count is 0.
  - FILL: each strobe writes `din`. `trig` is ignored. Go to ARMED on the edge where `occ` reaches the latched pre count.
  - ARMED: on a strobe with `trig`=0 and pre>0, write `din` and advance rd, so `occ` is unchanged. With pre=0, nothing is written. On a strobe with `trig`=1, write `din` (no drop), load the post counter with N-1 (N = latched post count), and go to POST, or to FLUSH if N-1==0.
  - POST: on each strobe, write `din` if `occ`<PRE_DEPTH or a transfer occurs that cycle; otherwise drop it and set `overrun`. The post counter decrements on every strobe, dropped or not. The strobe at which the counter equals 1 goes to FLUSH.
  - FLUSH: no writes. Drain the ring. On the transfer with `tlast`, go to IDLE and pulse `done` next cycle.
- `tvalid` = (POST or FLUSH) && `occ`>0. A transfer is `tvalid` && `tready`; it advances rd and decrements `occ`.
- `tlast` = FLUSH && `occ`==1.
- `abort` (priority over everything, including a simultaneous `arm`): next cycle state=IDLE, pointers and `occ`=0, `tvalid`=0, no `tlast`, no `done`. `overrun` is kept.
- Packet length = min(pre, samples seen before trigger) + N − dropped.

## Timing
- Reset: all outputs 0. State IDLE, pointers/`occ`/divider counter 0.
- `din` is captured at the `clk` edge where `sample_stb`=1. It appears on `tdata` at the earliest one cycle later.
- A trigger strobe at edge k gives `triggered`=1 and `tvalid`=1 (if `occ`>0) after edge k.
- Arm at edge k gives `armed`=1 after k. Strobes before k are not stored.
- Simultaneous write and transfer leave `occ` unchanged.
- Reset mid-capture gives the reset state on the next cycle.

## Test plan
- `ckdiv`=3, pre=4, post=4, `tready`=1, `din` = strobe index, trigger on strobe 10: `sample_stb` every 4 clocks; packet 6,7,8,9,10,11,12,13 with `tlast` on 13; `done` pulses once.
- Same setup with `tready`=0 throughout POST and PRE_DEPTH=8, post=10: after the ring is full, `overrun`=1; packet is 8 words with `tlast` on the 8th once `tready` rises.
- pre=0, post=0, trigger on strobe 3: single-word packet containing the strobe-3 sample with `tlast`=1.
- `trig` high from arm with pre=4: trigger ignored during FILL; first trigger taken on strobe 5 after arm; packet starts with strobes 1..4.
- `abort` during POST with `tvalid`=1: `tvalid`=0 next cycle, no `tlast`/`done`, state IDLE; `arm` and `abort` in the same cycle leaves `armed`=0.
- Change `ckdiv` 5→1 mid-ARMED: no strobe that cycle; next strobe 2 cycles later, then every 2 cycles.
